// File: rtl/register_bank.sv
// Multi-port register bank: two combinational read ports with write-through bypass,
// one write port, a mirrored result entry and a sequenced clear of every entry.
module register_bank #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 4,
   parameter int RESULT_IDX = (2 ** ADDR_W) - 1,
   parameter int ZERO_REG   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_done,
   output logic              wr_ack,
   output logic [DATA_W-1:0] result
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] RES_ADDR  = ADDR_W'(RESULT_IDX);
   localparam bit HAS_ZERO = (ZERO_REG != 0);

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_CLEARING = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              busy_q, busy_d;
   logic              clr_done_q, clr_done_d;
   logic              wr_ack_q, wr_ack_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              mem_we_s;
   logic [ADDR_W-1:0] mem_waddr_s;
   logic [DATA_W-1:0] mem_wdata_s;
   logic              bypass_s;

   // Next-state logic: a clear request outranks a write, and the clear walks one entry per cycle
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      busy_d      = busy_q;
      clr_done_d  = 1'b0;
      wr_ack_d    = 1'b0;
      mem_we_s    = 1'b0;
      mem_waddr_s = wr_addr;
      mem_wdata_s = wr_data;
      case (state_q)
         ST_IDLE: begin
            if (clr_req) begin
               state_d = ST_CLEARING;
               ptr_d   = '0;
               busy_d  = 1'b1;
            end else if (wr_en) begin
               wr_ack_d = 1'b1;
               mem_we_s = !(HAS_ZERO && (wr_addr == '0));
            end else begin
               wr_ack_d = 1'b0;
            end
         end
         ST_CLEARING: begin
            mem_we_s    = 1'b1;
            mem_waddr_s = ptr_q;
            mem_wdata_s = '0;
            ptr_d       = ptr_q + ADDR_W'(1);
            if (ptr_q == LAST_ADDR) begin
               state_d    = ST_IDLE;
               busy_d     = 1'b0;
               clr_done_d = 1'b1;
            end else begin
               state_d = ST_CLEARING;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ptr_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, storage and registered status outputs; reset wipes the whole bank at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         busy_q     <= 1'b0;
         clr_done_q <= 1'b0;
         wr_ack_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         busy_q     <= busy_d;
         clr_done_q <= clr_done_d;
         wr_ack_q   <= wr_ack_d;
         if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
         end
      end
   end

   // Read ports: bypass only a write that will actually be stored this edge
   always_comb begin
      bypass_s = (state_q == ST_IDLE) && wr_en && !clr_req;
      if (HAS_ZERO && (rd_addr_a == '0)) begin
         rd_data_a = '0;
      end else if (bypass_s && (rd_addr_a == wr_addr)) begin
         rd_data_a = wr_data;
      end else begin
         rd_data_a = mem_q[rd_addr_a];
      end
      if (HAS_ZERO && (rd_addr_b == '0)) begin
         rd_data_b = '0;
      end else if (bypass_s && (rd_addr_b == wr_addr)) begin
         rd_data_b = wr_data;
      end else begin
         rd_data_b = mem_q[rd_addr_b];
      end
   end

   assign result   = (HAS_ZERO && (RES_ADDR == '0)) ? '0 : mem_q[RES_ADDR];
   assign busy     = busy_q;
   assign clr_done = clr_done_q;
   assign wr_ack   = wr_ack_q;

endmodule

// File: tb/tb_register_bank.sv
// Randomized bench for register_bank: a plain and a ZERO_REG instance share stimulus
// and are compared against an array/counter reference model.
module tb_register_bank;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  rd_addr_a;
   logic [3:0]  rd_addr_b;
   logic        clr_req;
   logic [31:0] rd_data_a, rd_data_b, result;
   logic        busy, clr_done, wr_ack;
   logic [31:0] z_rd_data_a, z_rd_data_b, z_result;
   logic        z_busy, z_clr_done, z_wr_ack;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mem_m  [16];
   logic [31:0] memz_m [16];
   int          clr_left;
   int          clr_idx;
   logic        exp_ack;
   logic        exp_done;

   always #5 clk = ~clk;

   register_bank #(.DATA_W(32), .ADDR_W(4), .RESULT_IDX(15), .ZERO_REG(0)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .clr_req(clr_req), .busy(busy), .clr_done(clr_done), .wr_ack(wr_ack), .result(result)
   );

   register_bank #(.DATA_W(32), .ADDR_W(4), .RESULT_IDX(15), .ZERO_REG(1)) dut_z (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(z_rd_data_a), .rd_data_b(z_rd_data_b),
      .clr_req(clr_req), .busy(z_busy), .clr_done(z_clr_done), .wr_ack(z_wr_ack), .result(z_result)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [3:0] a, input bit zr);
      if (zr && a == 4'd0) return 32'd0;
      if (clr_left == 0 && wr_en && !clr_req && a == wr_addr) return wr_data;
      return zr ? memz_m[a] : mem_m[a];
   endfunction

   task automatic reset_model();
      for (int i = 0; i < 16; i++) begin
         mem_m[i]  = 32'd0;
         memz_m[i] = 32'd0;
      end
      clr_left = 0;
      clr_idx  = 0;
      exp_ack  = 1'b0;
      exp_done = 1'b0;
   endtask

   task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic clr, input logic [3:0] ra, input logic [3:0] rb);
      wr_en = we; wr_addr = wa; wr_data = wd; clr_req = clr; rd_addr_a = ra; rd_addr_b = rb;
   endtask

   // One clock: combinational reads checked before the edge, model stepped, status checked after
   task automatic cycle();
      @(negedge clk);
      if (!(clr_left == 0 && wr_en && clr_req)) begin
         check_eq("rd_a", rd_data_a, exp_read(rd_addr_a, 1'b0));
         check_eq("rd_b", rd_data_b, exp_read(rd_addr_b, 1'b0));
         check_eq("z_rd_a", z_rd_data_a, exp_read(rd_addr_a, 1'b1));
         check_eq("z_rd_b", z_rd_data_b, exp_read(rd_addr_b, 1'b1));
      end
      check_eq("result_pre", result, mem_m[15]);
      @(posedge clk);
      if (clr_left > 0) begin
         mem_m[clr_idx]  = 32'd0;
         memz_m[clr_idx] = 32'd0;
         clr_idx++;
         clr_left--;
         exp_ack  = 1'b0;
         exp_done = (clr_left == 0);
      end else begin
         exp_done = 1'b0;
         if (clr_req) begin
            clr_left = 16;
            clr_idx  = 0;
            exp_ack  = 1'b0;
         end else if (wr_en) begin
            mem_m[wr_addr] = wr_data;
            if (wr_addr != 4'd0) memz_m[wr_addr] = wr_data;
            exp_ack = 1'b1;
         end else begin
            exp_ack = 1'b0;
         end
      end
      #1;
      check_eq("wr_ack", 32'(wr_ack), 32'(exp_ack));
      check_eq("busy", 32'(busy), 32'(clr_left > 0));
      check_eq("clr_done", 32'(clr_done), 32'(exp_done));
      check_eq("z_wr_ack", 32'(z_wr_ack), 32'(exp_ack));
      check_eq("z_busy", 32'(z_busy), 32'(clr_left > 0));
      check_eq("z_clr_done", 32'(z_clr_done), 32'(exp_done));
      check_eq("result", result, mem_m[15]);
      check_eq("z_result", z_result, memz_m[15]);
   endtask

   task automatic fill_all();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 4'(i), $urandom() | 32'd1, 1'b0, 4'($urandom_range(15, 0)), 4'(i));
         cycle();
      end
   endtask

   initial begin
      int busy_cnt;
      bit done_seen;

      reset_model();
      rst_n = 1'b0;
      drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd15, 4'd0);
      #2;
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(clr_done), 32'd0);
      check_eq("rst_ack", 32'(wr_ack), 32'd0);
      check_eq("rst_result", result, 32'd0);
      check_eq("rst_rd_a", rd_data_a, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Write then read back; bypass in the same cycle
      drive(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 4'd1);
      cycle();
      check_eq("ack_after_write", 32'(wr_ack), 32'd1);
      drive(1'b1, 4'd5, 32'h12345678, 1'b0, 4'd3, 4'd5);
      @(negedge clk);
      check_eq("bypass_b", rd_data_b, 32'h12345678);
      check_eq("readback_a", rd_data_a, 32'hDEADBEEF);
      cycle();

      // ZERO_REG: write to entry 0 is acknowledged but never visible
      drive(1'b1, 4'd0, 32'h55, 1'b0, 4'd0, 4'd0);
      @(negedge clk);
      check_eq("z_zero_during", z_rd_data_a, 32'd0);
      cycle();
      check_eq("z_zero_ack", 32'(z_wr_ack), 32'd1);
      drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
      cycle();
      check_eq("z_zero_after", z_rd_data_a, 32'd0);
      check_eq("plain_zero_after", rd_data_a, 32'h55);

      // Random traffic with occasional clears
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(3, 0) != 0), 4'($urandom_range(15, 0)), $urandom(),
               ($urandom_range(49, 0) == 0), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
         cycle();
      end
      drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
      while (clr_left > 0) cycle();
      cycle();

      // Full clear: busy exactly 16 cycles, done on the 17th
      fill_all();
      drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd0, 4'd15);
      cycle();
      busy_cnt  = busy ? 1 : 0;
      done_seen = 1'b0;
      for (int i = 0; i < 40 && !done_seen; i++) begin
         drive(1'b0, 4'd0, 32'd0, $urandom_range(1, 0) == 1, 4'(i % 16), 4'((i + 1) % 16));
         cycle();
         if (clr_done) done_seen = 1'b1;
         else if (busy) busy_cnt++;
      end
      check_eq("clear_done_seen", 32'(done_seen), 32'd1);
      check_eq("clear_busy_cycles", busy_cnt, 32'd16);
      drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
      for (int i = 0; i < 16; i++) begin
         rd_addr_a = 4'(i);
         #1;
         check_eq("post_clear_zero", rd_data_a, 32'd0);
      end

      // Clear request with simultaneous write, then writes while clearing
      fill_all();
      drive(1'b1, 4'd2, 32'hAA, 1'b1, 4'd2, 4'd7);
      cycle();
      check_eq("dropped_write_ack", 32'(wr_ack), 32'd0);
      while (clr_left > 0) begin
         drive(1'b1, 4'($urandom_range(15, 0)), $urandom(), 1'b0, 4'($urandom_range(15, 0)), 4'd2);
         cycle();
      end
      drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd2, 4'd2);
      cycle();
      check_eq("entry2_zero", rd_data_a, 32'd0);

      // Reset in the middle of a clear
      fill_all();
      drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 4'd15);
      cycle();
      for (int i = 0; i < 7; i++) cycle();
      check_eq("mid_clear_entry8", 32'(mem_m[8] != 32'd0), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      reset_model();
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_done", 32'(clr_done), 32'd0);
      check_eq("abort_result", result, 32'd0);
      for (int i = 0; i < 16; i++) begin
         rd_addr_a = 4'(i);
         rd_addr_b = 4'(15 - i);
         #1;
         check_eq("abort_rd_a", rd_data_a, 32'd0);
         check_eq("abort_rd_b", rd_data_b, 32'd0);
      end
      drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive(($urandom_range(1, 0) == 1), 4'($urandom_range(15, 0)), $urandom(), 1'b0,
               4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of each register entry and data port.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning the address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter RESULT_IDX, default DEPTH-1, meaning the index of the entry mirrored on result.
REQ-004 SHALL have parameter ZERO_REG, default 0, meaning entry 0 is hardwired to zero when set to 1.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-006 SHALL have port rst_n, input, 1, the reset; asynchronous and active-low.
REQ-007 SHALL have port wr_en, input, 1, write request.
REQ-008 SHALL have port wr_addr, input, ADDR_W, write address.
REQ-009 SHALL have port wr_data, input, DATA_W, write data.
REQ-010 SHALL have ports rd_addr_a and rd_addr_b, input, ADDR_W each, read addresses.
REQ-011 SHALL have ports rd_data_a and rd_data_b, output, DATA_W each, read data.
REQ-012 SHALL have port clr_req, input, 1, request to zero all entries.
REQ-013 SHALL have port busy, output, 1, clear sequence in progress.
REQ-014 SHALL have port clr_done, output, 1, one-cycle pulse when a clear sequence completes.
REQ-015 SHALL have port wr_ack, output, 1, registered acknowledge of an accepted write.
REQ-016 SHALL have port result, output, DATA_W, combinational copy of entry RESULT_IDX.

Function
REQ-017 SHALL have a two-state FSM: IDLE and CLEARING, with an ADDR_W-bit clear pointer.
REQ-018 In IDLE, wr_en=1 at a rising edge SHALL store wr_data into wr_addr and set wr_ack=1 for the following cycle; otherwise wr_ack=0.
REQ-019 Reads SHALL be combinational: rd_data_x = entry[rd_addr_x], zero-latency.
REQ-020 In IDLE with wr_en=1 and rd_addr_x == wr_addr, rd_data_x SHALL return wr_data (write-through bypass) in the same cycle.
REQ-021 With ZERO_REG=1, entry 0 SHALL always read 0 and SHALL never be bypassed; writes to address 0 are acknowledged and discarded.
REQ-022 result SHALL reflect stored entry RESULT_IDX only, never bypassed data.
REQ-023 In IDLE, clr_req=1 at a rising edge SHALL move the FSM to CLEARING with pointer = 0; a simultaneous wr_en SHALL be dropped (no store, wr_ack=0).
REQ-024 In CLEARING, each rising edge SHALL zero entry[pointer] and increment pointer; after the edge that zeroes entry DEPTH-1 the FSM SHALL return to IDLE.
REQ-025 A clear sequence SHALL take exactly DEPTH cycles; busy=1 for exactly those DEPTH cycles, i.e. busy is 1 whenever the FSM is in CLEARING.
REQ-026 clr_done SHALL be 1 for exactly one cycle, the first cycle back in IDLE.
REQ-027 In CLEARING, wr_en SHALL be ignored (no store, wr_ack=0) and bypass SHALL be disabled; reads return stored (partially cleared) contents.
REQ-028 clr_req asserted while in CLEARING SHALL be ignored, with no restart.
REQ-029 Pointer wrap-around from DEPTH-1 SHALL not cause a second pass.
REQ-030 Out-of-range behaviour SHALL not exist: all ADDR_W-bit addresses are valid.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for clk, zero every entry, set FSM=IDLE, pointer=0, busy=0, clr_done=0, wr_ack=0; result, rd_data_a and rd_data_b therefore read 0 unless bypassed.
REQ-032 rst_n asserted mid-clear SHALL abort the sequence with no clr_done pulse; operation resumes in IDLE on the first edge after rst_n=1.

Verification
REQ-033 Write 0xDEADBEEF to addr 3, next cycle read A=3 -> rd_data_a=0xDEADBEEF; wr_ack=1 one cycle after the write edge.
REQ-034 wr_en=1, wr_addr=5, wr_data=0x12345678, rd_addr_b=5 in the same cycle -> rd_data_b=0x12345678 before the edge (bypass).
REQ-035 Fill all 16 entries, pulse clr_req -> busy=1 for 16 cycles, entries zero in order 0..15, clr_done=1 on cycle 17, then all reads=0.
REQ-036 Assert clr_req and wr_en (addr 2, 0xAA) in the same cycle; then wr_en during CLEARING -> no stores, wr_ack=0, entry 2 reads 0 after done.
REQ-037 Drop rst_n mid-clear at pointer=7 with entries 8..15 nonzero -> all entries 0 immediately, busy=0, no clr_done.
REQ-038 ZERO_REG=1: write 0x55 to addr 0 with rd_addr_a=0 -> rd_data_a=0 during and after the write, wr_ack=1.
